// File: rtl/block_allocator.sv
// Round-robin block allocator for the card linked-list RAM: ALLOC/FREE over valid/ready.
// Optional ALLOC_COUNT_EN keeps a live used-block count and short-circuits ALLOC on a full heap.
module block_allocator #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int STRIDE = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [ADDR_W-1:0] used_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clock,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int NUM_BLOCKS = (2 ** ADDR_W) / STRIDE;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] LAST_PROBE = ADDR_W'(NUM_BLOCKS - 2);

    typedef enum logic [2:0] {IDLE, RD, WAIT, CHK, WR, RESP, FULL} state_t;

    state_t            state, state_next;
    logic              op;
    logic [ADDR_W-1:0] target, ptr, probes;
    logic [ADDR_W-1:0] ptr_inc, ptr_step, fin_addr;
    logic              fin, fin_ok, adv, heap_full, bad_free, used_flag;
    logic              unused_q;

    assign unused_q  = ^ram_q[DATA_W-2:0];
    assign used_flag = ram_q[DATA_W-1];
    assign ptr_inc   = ptr + STEP;
    // Block 0 is the null pointer, so a wrap lands on the first real block.
    assign ptr_step  = (ptr_inc == '0) ? STEP : ptr_inc;
    assign bad_free  = (req_addr == '0) || ((req_addr & (STEP - 1'b1)) != '0);

    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_ok     = 1'b0;
        fin_addr   = '0;
        adv        = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (!req_op) state_next = heap_full ? FULL : RD;
                else if (bad_free) begin
                    state_next = RESP;
                    fin        = 1'b1;
                end else state_next = RD;
            end
            FULL: begin
                state_next = RESP;
                fin        = 1'b1;
            end
            RD:   state_next = WAIT;
            WAIT: state_next = CHK;
            CHK: begin
                if (!op) begin
                    if (!used_flag) state_next = WR;
                    else begin
                        adv = 1'b1;
                        if (probes == LAST_PROBE) begin
                            state_next = RESP;
                            fin        = 1'b1;
                        end else state_next = RD;
                    end
                end else if (used_flag) state_next = WR;
                else begin
                    state_next = RESP;
                    fin        = 1'b1;
                end
            end
            WR: begin
                state_next = RESP;
                fin        = 1'b1;
                fin_ok     = 1'b1;
                fin_addr   = op ? target : ptr;
                adv        = !op;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= 1'b0;
            target    <= '0;
            ptr       <= STEP;
            probes    <= '0;
            resp_ok   <= 1'b0;
            resp_addr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                op     <= req_op;
                target <= req_addr;
                probes <= '0;
            end
            if (adv) ptr <= ptr_step;
            if (state == CHK && !op && used_flag) probes <= probes + 1'b1;
            if (fin) begin
                resp_ok   <= fin_ok;
                resp_addr <= fin_addr;
            end
        end
    end

`ifdef ALLOC_COUNT_EN
    localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(NUM_BLOCKS - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) used_count <= '0;
        else if (state == WR) used_count <= op ? used_count - 1'b1 : used_count + 1'b1;
    end
    assign heap_full = (used_count == FULL_CNT);
`else
    assign used_count = '0;
    assign heap_full  = 1'b0;
`endif

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign ram_wren    = (state == WR);
    assign ram_clock   = clock;
    assign ram_data    = (state == WR && !op) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    assign ram_address = (state inside {RD, WAIT, CHK, WR}) ? (op ? target : ptr) : '0;
endmodule

// File: tb/tb_block_allocator.sv
// Bench for block_allocator: 2-cycle-latency RAM model, block-level heap model, per-cycle compare.
module tb_block_allocator;
    localparam int ADDR_W = 10, DATA_W = 32, STRIDE = 32;
    localparam int NB = (2 ** ADDR_W) / STRIDE;

    logic clock = 0, reset = 1, req_valid = 0, req_op = 0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic req_ready, resp_valid, resp_ok, ram_clock, ram_wren;
    logic [ADDR_W-1:0] resp_addr, used_count, ram_address;
    logic [DATA_W-1:0] ram_data, ram_q, q1;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    block_allocator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRIDE(STRIDE)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .resp_valid(resp_valid), .resp_ok(resp_ok),
        .resp_addr(resp_addr), .used_count(used_count), .ram_address(ram_address),
        .ram_clock(ram_clock), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q));

    always #5 clock = ~clock;

    always @(posedge ram_clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        q1    <= mem[ram_address];
        ram_q <= q1;
    end

    int n_cmp = 0, n_bad = 0;
    bit m_used [NB];
    int m_ptr, m_cnt;
    bit inflight = 0;
    int cyc, wren_cnt;
    bit exp_ok, hold_ok;
    int exp_addr, exp_lat, exp_wren, exp_waddr, hold_addr;
    logic [DATA_W-1:0] exp_data;
    int obs_ok, obs_addr, obs_lat;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 1; m_cnt = 0; hold_ok = 0; hold_addr = 0;
        for (int b = 0; b < NB; b++) m_used[b] = 0;
    endtask

    function automatic int nxt(int i);
        return (i == NB - 1) ? 1 : i + 1;
    endfunction

    task automatic model_alloc();
        int idx;
        exp_ok = 0; exp_addr = 0; exp_lat = 3 * (NB - 1) + 1;
`ifdef ALLOC_COUNT_EN
        if (m_cnt == NB - 1) begin exp_lat = 2; return; end
`endif
        idx = m_ptr;
        for (int k = 0; k < NB - 1; k++) begin
            if (!m_used[idx]) begin
                exp_ok = 1; exp_addr = idx * STRIDE; exp_lat = 3 * (k + 1) + 2;
                m_used[idx] = 1; m_ptr = nxt(idx); m_cnt++;
                return;
            end
            idx = nxt(idx);
        end
    endtask

    task automatic model_free(int a);
        exp_ok = 0; exp_addr = 0;
        if (a == 0 || a % STRIDE != 0) exp_lat = 1;
        else if (m_used[a / STRIDE]) begin
            exp_ok = 1; exp_addr = a; exp_lat = 5;
            m_used[a / STRIDE] = 0; m_cnt--;
        end else exp_lat = 4;
    endtask

    always @(negedge clock) begin
        if (inflight) begin
            cyc++;
            chk("busy_ready", req_ready, 0);
            if (ram_wren) begin
                wren_cnt++;
                chk("wren_addr", ram_address, exp_waddr);
                chk("wren_data", ram_data, exp_data);
            end
            if (resp_valid) begin
                chk("resp_ok", resp_ok, exp_ok);
                chk("resp_addr", resp_addr, exp_addr);
                chk("latency", cyc, exp_lat);
                chk("wren_pulses", wren_cnt, exp_wren);
`ifdef ALLOC_COUNT_EN
                chk("used_count", used_count, m_cnt);
`else
                chk("used_count", used_count, 0);
`endif
                obs_ok = resp_ok; obs_addr = resp_addr; obs_lat = cyc;
                hold_ok = exp_ok; hold_addr = exp_addr;
                inflight = 0;
            end
        end else begin
            chk("idle_ready", req_ready, 1);
            chk("idle_wren", ram_wren, 0);
            chk("idle_resp", resp_valid, 0);
            chk("hold_ok", resp_ok, hold_ok);
            chk("hold_addr", resp_addr, hold_addr);
        end
    end

    task automatic issue(bit op, int a);
        @(negedge clock);
        req_valid = 1; req_op = op; req_addr = ADDR_W'(a);
        if (op) model_free(a); else model_alloc();
        exp_wren  = exp_ok ? 1 : 0;
        exp_waddr = op ? a : exp_addr;
        exp_data  = op ? '0 : 32'h8000_0000;
        @(posedge clock);
        cyc = 0; wren_cnt = 0; inflight = 1;
        #1 req_valid = 0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 400 && inflight; i++) @(negedge clock);
        if (inflight) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: got none want resp_valid");
            inflight = 0;
        end
    endtask

    task automatic do_op(bit op, int a);
        issue(op, a);
        wait_resp();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #1 inflight = 0; reset = 1;
        model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        @(negedge clock);
        #1 reset = 0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_ok", resp_ok, 0);
        chk("rst_resp_addr", resp_addr, 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_used", used_count, 0);
        #1 reset = 0;

        do_op(0, 0);
        chk("t1_addr", obs_addr, 32);
        chk("t1_lat", obs_lat, 5);
        chk("t1_mem32", mem[32], 32'h8000_0000);

        for (int i = 0; i < NB - 2; i++) do_op(0, 0);
        chk("t2_last_addr", obs_addr, 992);
        do_op(0, 0);
        chk("t2_full_ok", obs_ok, 0);
        chk("t2_full_addr", obs_addr, 0);
`ifdef ALLOC_COUNT_EN
        chk("t2_full_lat", obs_lat, 2);
`else
        chk("t2_full_lat", obs_lat, 94);
`endif

        do_op(1, 320);
        chk("t3_free_ok", obs_ok, 1);
        chk("t3_mem320", mem[320], 0);
        do_op(0, 0);
        chk("t3_realloc", obs_addr, 320);

        do_op(1, 320);
        chk("t4_free1", obs_ok, 1);
        do_op(1, 320);
        chk("t4_double", obs_ok, 0);
        do_op(1, 0);
        chk("t4_free0_lat", obs_lat, 1);
        do_op(1, 33);
        chk("t4_free33_ok", obs_ok, 0);

        pulse_reset();
        mem[32] = 32'h8000_0000; mem[64] = 32'h8000_0000;
        m_used[1] = 1; m_used[2] = 1;
        do_op(0, 0);
        chk("t5_addr", obs_addr, 96);
        chk("t5_lat", obs_lat, 11);

        pulse_reset();
        issue(0, 0);
        repeat (2) @(negedge clock);
        #1 inflight = 0; reset = 1;
        #1;
        chk("t6_wren", ram_wren, 0);
        chk("t6_ready", req_ready, 1);
        chk("t6_ram_addr", ram_address, 0);
        model_reset();
        @(negedge clock);
        #1 reset = 0;
        chk("t6_mem32", mem[32], 0);
        do_op(0, 0);
        chk("t6_addr", obs_addr, 32);
        chk("t6_lat", obs_lat, 5);

        for (int b = 1; b < NB; b++) chk("final_flag", mem[b * STRIDE][DATA_W-1], m_used[b]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
